sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Sequences 32-bit bus accesses from the femto data bus onto the board's external asynchronous 8-bit SRAM (19-bit byte address; active-low CE, OE and WE).
- Splits each byte, half or word request into per-byte SRAM cycles.
- Enforces programmable read-access and write-pulse widths.
- Drives the SRAM data pins through an explicit out/oe/in split; the top-level wrapper builds the tristate.

Parameters:
- RD_CYC, 2, clock cycles CE/OE are held low per byte read; data is sampled at the end of the last cycle; legal 1..15.
- WR_CYC, 2, clock cycles WE is held low per byte write; legal 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- s_req  in  1  request valid.
- s_ready  out  1  request accepted when s_req & s_ready.
- s_we  in  1  1=write, 0=read.
- s_size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- s_addr  in  19  byte address.
- s_wdata  in  32  write data, little-endian (byte k at s_addr+k is s_wdata[8k+:8]).
- s_rdata  out  32  read data, zero-extended, byte k in [8k+:8]; valid while s_resp=1.
- s_resp  out  1  one-cycle completion pulse.
- s_err  out  1  valid with s_resp; 1 = request rejected.
- sram_ce_bar  out  1  chip enable.
- sram_oe_bar  out  1  output enable.
- sram_we_bar  out  1  write enable.
- sram_addr  out  19  SRAM address.
- sram_dout  out  8  data driven to SRAM.
- sram_doe  out  1  1 = controller drives sram_data.
- sram_din  in  8  data from SRAM pins.

Behaviour:
- Reset (rst=0, immediate, asynchronous): state=IDLE, ce/oe/we_bar=1, sram_doe=0, sram_addr=0, sram_dout=0, s_rdata=0, s_resp=0, s_err=0, s_ready=1. Asserting reset mid-access aborts it immediately with no response; a partial write may leave some bytes written.
- States: IDLE, RD, WR, WHOLD, DONE. All outputs are registered.
- IDLE: s_ready=1. On handshake, latch we, addr, wdata and the byte count N (1, 2 or 4); set the byte index to 0 and clear s_rdata.
  - Illegal request (s_size=3, half with addr[0]=1, or word with addr[1:0]!=0) goes directly to DONE with s_err=1. No SRAM pin toggles.
- RD: for RD_CYC cycles drive ce_bar=0, oe_bar=0, we_bar=1, sram_addr=base+idx.
  - On the final cycle, capture sram_din into s_rdata[8*idx+:8].
  - Then idx+1: stay in RD for the next byte (ce and oe remain low, address steps), or go to DONE after byte N-1.
- WR: for WR_CYC cycles drive ce_bar=0, we_bar=0, oe_bar=1, sram_doe=1, sram_dout=wdata byte idx, sram_addr=base+idx. Then go to WHOLD.
- WHOLD: exactly 1 cycle with we_bar=1, ce_bar=0, address and data unchanged, sram_doe=1. This gives address/data hold after the rising edge of WE. Then the next byte goes to WR, or after byte N-1 go to DONE.
- DONE: ce/oe/we_bar=1, sram_doe=0, s_resp=1 for exactly 1 cycle, s_ready=0. Next state is IDLE. A new request can be accepted at the earliest on the cycle after DONE.
- Latency (handshake edge to s_resp high): read = N*RD_CYC+1 cycles; write = N*(WR_CYC+1)+1 cycles; illegal = 1 cycle.
- sram_doe is never 1 while oe_bar=0, including across state transitions.
- s_rdata holds its value until the next accepted read.
- Aligned requests cannot wrap the 19-bit space. Address arithmetic is 19-bit modulo.
- s_req while s_ready=0 is ignored; requesters hold s_req until the handshake.
- s_err=0 on every legal response.

Test Plan:
- Word write 0xDEADBEEF @0x00100 (WR_CYC=2): 4 WE-low pulses of 2 cycles each at addresses 0x100..0x103 with data EF,BE,AD,DE. s_resp arrives 13 cycles after the handshake with s_err=0. A following word read returns s_rdata=0xDEADBEEF after 9 cycles.
- Byte read @0x00103 after the previous write: s_rdata=0x000000DE. Half read @0x00102: s_rdata=0x0000DEAD. In both cases CE stays low continuously across the bytes of the access.
- Misaligned half @0x00101, word @0x00102, and s_size=3: each gives s_resp with s_err=1 one cycle after the handshake. ce_bar, oe_bar, we_bar and sram_doe never toggle. The earlier memory contents are unchanged.
- RD_CYC=3 and WR_CYC=1 instance, byte write 0x5A @0x7FFFF then read it back: WE is low for 1 cycle followed by 1 hold cycle. The read yields 0x0000005A with latency 4.
- Reset asserted in the second byte of a word write: all SRAM controls go to 1 and sram_doe goes to 0 in the same timestep, with no s_resp. After reset is released, s_ready=1 and a new read completes normally.
- Back-to-back: a requester holds s_req continuously with read, write, read. Each handshake occurs exactly one cycle after the preceding DONE. A bus monitor checks that sram_doe & ~oe_bar is never true.

Source files
------------

// File: rtl/sram_ctrl.sv
// Byte-serial sequencer from 32-bit byte/half/word bus requests onto an asynchronous x8 SRAM.
// Every output is a register loaded from a decode of the state being entered, so pins never glitch.
module sram_ctrl #(
    parameter int RD_CYC = 2,
    parameter int WR_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_req,
    output logic        s_ready,
    input  logic        s_we,
    input  logic [1:0]  s_size,
    input  logic [18:0] s_addr,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
    output logic        s_resp,
    output logic        s_err,
    output logic        sram_ce_bar,
    output logic        sram_oe_bar,
    output logic        sram_we_bar,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        sram_doe,
    input  logic [7:0]  sram_din
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WR    = 3'd2,
        WHOLD = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] RD_LAST = 4'(RD_CYC - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_CYC - 1);

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [1:0]  r_idx, w_idx_next;
    logic [1:0]  r_last, w_last_next;
    logic [18:0] r_base, w_base_next;
    logic [31:0] r_wdata, w_wdata_next;
    logic        r_err, w_err_next;
    logic [31:0] r_rdata, w_rdata_next;

    logic        r_ready, w_ready_next;
    logic        r_resp, w_resp_next;
    logic        r_serr, w_serr_next;
    logic        r_ce_bar, w_ce_bar_next;
    logic        r_oe_bar, w_oe_bar_next;
    logic        r_we_bar, w_we_bar_next;
    logic [18:0] r_sram_addr, w_sram_addr_next;
    logic [7:0]  r_sram_dout, w_sram_dout_next;
    logic        r_doe, w_doe_next;

    logic        w_hs;
    logic        w_legal;
    logic [1:0]  w_req_last;

    assign w_hs = s_req & r_ready;

    // Half must be even, word must be 4-aligned; size 3 is never legal.
    always_comb begin
        w_legal    = 1'b0;
        w_req_last = 2'd0;
        case (s_size)
            2'd0: begin
                w_legal    = 1'b1;
                w_req_last = 2'd0;
            end
            2'd1: begin
                w_legal    = ~s_addr[0];
                w_req_last = 2'd1;
            end
            2'd2: begin
                w_legal    = (s_addr[1:0] == 2'b00);
                w_req_last = 2'd3;
            end
            default: begin
                w_legal    = 1'b0;
                w_req_last = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_last_next  = r_last;
        w_base_next  = r_base;
        w_wdata_next = r_wdata;
        w_err_next   = r_err;
        w_rdata_next = r_rdata;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_base_next  = s_addr;
                    w_wdata_next = s_wdata;
                    w_last_next  = w_req_last;
                    w_idx_next   = 2'd0;
                    w_cnt_next   = 4'd0;
                    w_err_next   = ~w_legal;
                    if (!s_we) begin
                        w_rdata_next = 32'd0;
                    end
                    if (!w_legal) begin
                        w_state_next = DONE;
                    end else if (s_we) begin
                        w_state_next = WR;
                    end else begin
                        w_state_next = RD;
                    end
                end
            end
            RD: begin
                if (r_cnt == RD_LAST) begin
                    w_rdata_next[{r_idx, 3'b000} +: 8] = sram_din;
                    w_cnt_next = 4'd0;
                    if (r_idx == r_last) begin
                        w_state_next = DONE;
                    end else begin
                        w_idx_next = r_idx + 2'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            WR: begin
                if (r_cnt == WR_LAST) begin
                    w_cnt_next   = 4'd0;
                    w_state_next = WHOLD;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            WHOLD: begin
                if (r_idx == r_last) begin
                    w_state_next = DONE;
                end else begin
                    w_idx_next   = r_idx + 2'd1;
                    w_state_next = WR;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pin values for the state being entered; address and data hold outside of RD/WR.
    always_comb begin
        w_ready_next     = 1'b0;
        w_resp_next      = 1'b0;
        w_serr_next      = 1'b0;
        w_ce_bar_next    = 1'b1;
        w_oe_bar_next    = 1'b1;
        w_we_bar_next    = 1'b1;
        w_doe_next       = 1'b0;
        w_sram_addr_next = r_sram_addr;
        w_sram_dout_next = r_sram_dout;
        case (w_state_next)
            IDLE: begin
                w_ready_next = 1'b1;
            end
            RD: begin
                w_ce_bar_next    = 1'b0;
                w_oe_bar_next    = 1'b0;
                w_sram_addr_next = w_base_next + {17'd0, w_idx_next};
            end
            WR: begin
                w_ce_bar_next    = 1'b0;
                w_we_bar_next    = 1'b0;
                w_doe_next       = 1'b1;
                w_sram_addr_next = w_base_next + {17'd0, w_idx_next};
                w_sram_dout_next = w_wdata_next[{w_idx_next, 3'b000} +: 8];
            end
            WHOLD: begin
                w_ce_bar_next = 1'b0;
                w_doe_next    = 1'b1;
            end
            DONE: begin
                w_resp_next = 1'b1;
                w_serr_next = w_err_next;
            end
            default: begin
                w_ready_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= 2'd0;
            r_last      <= 2'd0;
            r_base      <= 19'd0;
            r_wdata     <= 32'd0;
            r_err       <= 1'b0;
            r_rdata     <= 32'd0;
            r_ready     <= 1'b1;
            r_resp      <= 1'b0;
            r_serr      <= 1'b0;
            r_ce_bar    <= 1'b1;
            r_oe_bar    <= 1'b1;
            r_we_bar    <= 1'b1;
            r_sram_addr <= 19'd0;
            r_sram_dout <= 8'd0;
            r_doe       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_last      <= w_last_next;
            r_base      <= w_base_next;
            r_wdata     <= w_wdata_next;
            r_err       <= w_err_next;
            r_rdata     <= w_rdata_next;
            r_ready     <= w_ready_next;
            r_resp      <= w_resp_next;
            r_serr      <= w_serr_next;
            r_ce_bar    <= w_ce_bar_next;
            r_oe_bar    <= w_oe_bar_next;
            r_we_bar    <= w_we_bar_next;
            r_sram_addr <= w_sram_addr_next;
            r_sram_dout <= w_sram_dout_next;
            r_doe       <= w_doe_next;
        end
    end

    assign s_ready     = r_ready;
    assign s_rdata     = r_rdata;
    assign s_resp      = r_resp;
    assign s_err       = r_serr;
    assign sram_ce_bar = r_ce_bar;
    assign sram_oe_bar = r_oe_bar;
    assign sram_we_bar = r_we_bar;
    assign sram_addr   = r_sram_addr;
    assign sram_dout   = r_sram_dout;
    assign sram_doe    = r_doe;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (RD2/WR2 and RD3/WR1) each on a cycle-sampled SRAM model,
// directed vector table, hand-written reset/back-to-back sequences and a randomized reference check.
module tb_sram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req     [2];
    logic        we_i    [2];
    logic [1:0]  size_i  [2];
    logic [18:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic        rdy     [2];
    logic [31:0] rdata   [2];
    logic        resp    [2];
    logic        err     [2];
    logic        ce      [2];
    logic        oe      [2];
    logic        wen     [2];
    logic [18:0] saddr   [2];
    logic [7:0]  sdout   [2];
    logic        sdoe    [2];
    logic [7:0]  sdin    [2];

    logic [7:0]  mem0 [0:524287];
    logic [7:0]  mem1 [0:524287];
    logic        we_prev [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_u
        sram_ctrl #(
            .RD_CYC((gi == 0) ? 2 : 3),
            .WR_CYC((gi == 0) ? 2 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .s_req      (req[gi]),
            .s_ready    (rdy[gi]),
            .s_we       (we_i[gi]),
            .s_size     (size_i[gi]),
            .s_addr     (addr_i[gi]),
            .s_wdata    (wdata_i[gi]),
            .s_rdata    (rdata[gi]),
            .s_resp     (resp[gi]),
            .s_err      (err[gi]),
            .sram_ce_bar(ce[gi]),
            .sram_oe_bar(oe[gi]),
            .sram_we_bar(wen[gi]),
            .sram_addr  (saddr[gi]),
            .sram_dout  (sdout[gi]),
            .sram_doe   (sdoe[gi]),
            .sram_din   (sdin[gi])
        );
    end

    assign sdin[0] = (!ce[0] && !oe[0]) ? mem0[saddr[0]] : 8'h00;
    assign sdin[1] = (!ce[1] && !oe[1]) ? mem1[saddr[1]] : 8'h00;

    // SRAM stores on the rising edge of WE while selected and driven.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst) begin
                we_prev[u] <= 1'b1;
            end else begin
                if (!we_prev[u] && wen[u] && !ce[u] && sdoe[u]) begin
                    if (u == 0) mem0[saddr[0]] <= sdout[0];
                    else        mem1[saddr[1]] <= sdout[1];
                end
                we_prev[u] <= wen[u];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          waitc;
        int          ce_low;
        int          ce_falls;
        int          oe_low;
        int          doe_hi;
        int          we_low;
        int          we_pulses;
        int          bad_width;
        int          no_hold;
        int          bus_viol;
    } obs_t;

    typedef struct {
        int          u;
        logic        w;
        logic [1:0]  sz;
        logic [18:0] a;
        logic [31:0] wd;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    logic [7:0] ref_mem [0:511];

    function automatic int rd_cyc(input int u);
        return (u == 0) ? 2 : 3;
    endfunction

    function automatic int wr_cyc(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    function automatic bit is_legal(input logic [1:0] sz, input logic [18:0] a);
        return (sz == 2'd0) || (sz == 2'd1 && !a[0]) || (sz == 2'd2 && a[1:0] == 2'b00);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic txn(input int u, input logic w, input logic [1:0] sz, input logic [18:0] a,
                       input logic [31:0] wd, input bit keep, output obs_t o);
        logic        ce_p;
        logic        we_p;
        logic [18:0] a_p;
        int          run;
        o = '{default: 0};
        @(negedge clk);
        req[u]     = 1'b1;
        we_i[u]    = w;
        size_i[u]  = sz;
        addr_i[u]  = a;
        wdata_i[u] = wd;
        while (!rdy[u] && o.waitc < 100) begin
            @(negedge clk);
            o.waitc++;
        end
        if (!rdy[u]) begin
            req[u] = 1'b0;
            o.lat  = -1;
            return;
        end
        @(posedge clk);
        #1;
        if (!keep) req[u] = 1'b0;
        ce_p = 1'b1;
        we_p = 1'b1;
        a_p  = saddr[u];
        run  = 0;
        while (o.lat < 200) begin
            @(negedge clk);
            o.lat++;
            if (!ce[u]) o.ce_low++;
            if (!ce[u] && ce_p) o.ce_falls++;
            if (!oe[u]) o.oe_low++;
            if (sdoe[u]) o.doe_hi++;
            if (sdoe[u] && !oe[u]) o.bus_viol++;
            if (!wen[u]) begin
                o.we_low++;
                run++;
                if (we_p) o.we_pulses++;
            end else if (!we_p) begin
                if (run != wr_cyc(u)) o.bad_width++;
                if (ce[u] || !sdoe[u] || saddr[u] != a_p) o.no_hold++;
                run = 0;
            end
            ce_p = ce[u];
            we_p = wen[u];
            a_p  = saddr[u];
            if (resp[u]) break;
        end
        o.err   = err[u];
        o.rdata = rdata[u];
        $display("txn u%0d we=%0b sz=%0d a=%05h wd=%08h -> err=%0b rd=%08h lat=%0d",
                 u, w, sz, a, wd, o.err, o.rdata, o.lat);
    endtask

    // Expected pin activity comes straight from the per-byte cycle budgets.
    task automatic check_obs(input string nm, input int u, input logic w, input logic [1:0] sz,
                             input logic [18:0] a, input obs_t o);
        bit lg;
        int n;
        int cyc;
        lg  = is_legal(sz, a);
        n   = nbytes(sz);
        cyc = !lg ? 0 : (w ? n * (wr_cyc(u) + 1) : n * rd_cyc(u));
        check({nm, ".lat"},       o.lat, cyc + 1);
        check({nm, ".err"},       {31'd0, o.err}, {31'd0, !lg});
        check({nm, ".ce_low"},    o.ce_low, cyc);
        check({nm, ".ce_falls"},  o.ce_falls, lg ? 1 : 0);
        check({nm, ".oe_low"},    o.oe_low, (lg && !w) ? cyc : 0);
        check({nm, ".doe_hi"},    o.doe_hi, (lg && w) ? cyc : 0);
        check({nm, ".we_low"},    o.we_low, (lg && w) ? n * wr_cyc(u) : 0);
        check({nm, ".we_pulses"}, o.we_pulses, (lg && w) ? n : 0);
        check({nm, ".we_width"},  o.bad_width, 0);
        check({nm, ".we_hold"},   o.no_hold, 0);
        check({nm, ".bus"},       o.bus_viol, 0);
    endtask

    initial begin : main
        vec_t        tbl [14];
        obs_t        o;
        int          ru;
        logic        rw;
        logic [1:0]  rsz;
        logic [18:0] ra;
        logic [31:0] rwd;
        logic [31:0] exp_rd;
        int          off;
        int          nb;

        for (int u = 0; u < 2; u++) begin
            req[u] = 1'b0; we_i[u] = 1'b0; size_i[u] = 2'd0;
            addr_i[u] = 19'd0; wdata_i[u] = 32'd0;
        end

        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset_ctl_u%0d", u),
                  {25'd0, rdy[u], resp[u], err[u], ce[u], oe[u], wen[u], sdoe[u]}, 32'b1001110);
            check($sformatf("reset_addr_u%0d", u), {13'd0, saddr[u]}, 32'd0);
            check($sformatf("reset_dout_u%0d", u), {24'd0, sdout[u]}, 32'd0);
            check($sformatf("reset_rdata_u%0d", u), rdata[u], 32'd0);
        end
        rst = 1'b1;

        tbl[0]  = '{0, 1'b1, 2'd2, 19'h00100, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{0, 1'b0, 2'd2, 19'h00100, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{0, 1'b0, 2'd0, 19'h00103, 32'h0,        1'b0, 32'h000000DE};
        tbl[3]  = '{0, 1'b0, 2'd1, 19'h00102, 32'h0,        1'b0, 32'h0000DEAD};
        tbl[4]  = '{0, 1'b0, 2'd1, 19'h00101, 32'h0,        1'b1, 32'h0};
        tbl[5]  = '{0, 1'b0, 2'd2, 19'h00102, 32'h0,        1'b1, 32'h0};
        tbl[6]  = '{0, 1'b0, 2'd3, 19'h00100, 32'h0,        1'b1, 32'h0};
        tbl[7]  = '{0, 1'b1, 2'd1, 19'h00101, 32'h11111111, 1'b1, 32'h0};
        tbl[8]  = '{0, 1'b0, 2'd2, 19'h00100, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[9]  = '{1, 1'b1, 2'd0, 19'h7FFFF, 32'h0000005A, 1'b0, 32'h0};
        tbl[10] = '{1, 1'b0, 2'd0, 19'h7FFFF, 32'h0,        1'b0, 32'h0000005A};
        tbl[11] = '{1, 1'b1, 2'd1, 19'h7FFFE, 32'h0000CAFE, 1'b0, 32'h0};
        tbl[12] = '{1, 1'b0, 2'd1, 19'h7FFFE, 32'h0,        1'b0, 32'h0000CAFE};
        tbl[13] = '{0, 1'b0, 2'd0, 19'h00100, 32'h0,        1'b0, 32'h000000EF};

        for (int i = 0; i < 14; i++) begin
            txn(tbl[i].u, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, 1'b0, o);
            check_obs($sformatf("vec%0d", i), tbl[i].u, tbl[i].w, tbl[i].sz, tbl[i].a, o);
            check($sformatf("vec%0d.err_tbl", i), {31'd0, o.err}, {31'd0, tbl[i].e_err});
            if (!tbl[i].w && !tbl[i].e_err)
                check($sformatf("vec%0d.rdata", i), o.rdata, tbl[i].e_rdata);
        end
        check("mem_word_0x100", {mem0[19'h103], mem0[19'h102], mem0[19'h101], mem0[19'h100]}, 32'hDEADBEEF);
        check("mem_half_0x7fffe", {16'd0, mem1[19'h7FFFF], mem1[19'h7FFFE]}, 32'h0000CAFE);

        // Back-to-back with s_req held high: read, write, read.
        txn(0, 1'b0, 2'd2, 19'h00100, 32'h0, 1'b1, o);
        check_obs("b2b0", 0, 1'b0, 2'd2, 19'h00100, o);
        check("b2b0.rdata", o.rdata, 32'hDEADBEEF);
        txn(0, 1'b1, 2'd2, 19'h00104, 32'h12345678, 1'b1, o);
        check_obs("b2b1", 0, 1'b1, 2'd2, 19'h00104, o);
        check("b2b1.wait", o.waitc, 0);
        txn(0, 1'b0, 2'd2, 19'h00104, 32'h0, 1'b0, o);
        check_obs("b2b2", 0, 1'b0, 2'd2, 19'h00104, o);
        check("b2b2.wait", o.waitc, 0);
        check("b2b2.rdata", o.rdata, 32'h12345678);

        // Reset during the second byte of a word write.
        @(negedge clk);
        check("rst_seq.ready", {31'd0, rdy[0]}, 32'd1);
        req[0] = 1'b1; we_i[0] = 1'b1; size_i[0] = 2'd2;
        addr_i[0] = 19'h00200; wdata_i[0] = 32'h11223344;
        @(posedge clk);
        #1 req[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_seq.byte1_pins", {29'd0, wen[0], sdoe[0], ce[0]}, 32'b010);
        check("rst_seq.byte1_addr", {13'd0, saddr[0]}, 32'h00201);
        #1 rst = 1'b0;
        #1;
        check("rst_seq.pins_now", {27'd0, ce[0], oe[0], wen[0], sdoe[0], resp[0]}, 32'b11100);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        begin : post_rst
            int resp_seen;
            resp_seen = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (resp[0]) resp_seen++;
            end
            check("rst_seq.no_resp", resp_seen, 0);
            check("rst_seq.ready_after", {31'd0, rdy[0]}, 32'd1);
        end
        check("rst_seq.byte0_written", {24'd0, mem0[19'h00200]}, 32'h44);
        txn(0, 1'b0, 2'd2, 19'h00100, 32'h0, 1'b0, o);
        check_obs("rst_seq.read", 0, 1'b0, 2'd2, 19'h00100, o);
        check("rst_seq.rdata", o.rdata, 32'hDEADBEEF);

        // Randomized traffic in a 256-byte window per unit, checked against a flat byte-array model.
        for (int u = 0; u < 2; u++) begin
            for (int w4 = 0; w4 < 64; w4++) begin
                rwd = $urandom;
                ra  = 19'h01000 + 19'(w4 * 4);
                txn(u, 1'b1, 2'd2, ra, rwd, 1'b0, o);
                check_obs($sformatf("fill_u%0d_%0d", u, w4), u, 1'b1, 2'd2, ra, o);
                for (int k = 0; k < 4; k++) ref_mem[u * 256 + w4 * 4 + k] = rwd[8 * k +: 8];
            end
        end
        for (int i = 0; i < 120; i++) begin
            ru  = int'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            off = int'($urandom_range(0, 255));
            ra  = 19'h01000 + 19'(off);
            rwd = $urandom;
            txn(ru, rw, rsz, ra, rwd, 1'b0, o);
            check_obs($sformatf("rnd%0d", i), ru, rw, rsz, ra, o);
            if (is_legal(rsz, ra)) begin
                nb = nbytes(rsz);
                if (rw) begin
                    for (int k = 0; k < nb; k++) ref_mem[ru * 256 + off + k] = rwd[8 * k +: 8];
                end else begin
                    exp_rd = 32'd0;
                    for (int k = 0; k < nb; k++) exp_rd[8 * k +: 8] = ref_mem[ru * 256 + off + k];
                    check($sformatf("rnd%0d.rdata", i), o.rdata, exp_rd);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
